// File: rtl/pampy_fetch_unit.sv
// Instruction prefetch unit: keeps a two-entry buffer of {opcode, argument, pc}
// filled from program memory with at most one read in flight; jumps flush it.
module pampy_fetch_unit #(
  parameter int ADDR_WIDTH        = 12,
  parameter int DATA_WIDTH        = 8,
  parameter int INSTRUCTION_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         MEM_REQ,
  output logic [ADDR_WIDTH-1:0]        MEM_ADDR,
  input  logic                         MEM_RVALID,
  input  logic [INSTRUCTION_WIDTH-1:0] MEM_RDATA,
  output logic                         INSTR_VALID,
  input  logic                         INSTR_READY,
  output logic [DATA_WIDTH-1:0]        INSTR_OUT,
  output logic [DATA_WIDTH-1:0]        ARG_OUT,
  output logic [ADDR_WIDTH-1:0]        INSTR_PC,
  input  logic                         JUMP_EN,
  input  logic [ADDR_WIDTH-1:0]        JUMP_ADDR,
  output logic [1:0]                   BUF_COUNT
);

  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;
  localparam logic [ADDR_WIDTH-1:0] PC_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PC_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] D_ZERO  = {DATA_WIDTH{1'b0}};

  logic [1:0]            state_r;
  logic [ADDR_WIDTH-1:0] fetch_pc_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic                  mem_req_r;
  logic [1:0]            count_r;
  logic                  valid_r;
  logic [DATA_WIDTH-1:0] head_op_r;
  logic [DATA_WIDTH-1:0] head_arg_r;
  logic [ADDR_WIDTH-1:0] head_pc_r;
  logic [DATA_WIDTH-1:0] tail_op_r;
  logic [DATA_WIDTH-1:0] tail_arg_r;
  logic [ADDR_WIDTH-1:0] tail_pc_r;

  logic                  issue_s;
  logic                  push_s;
  logic                  pop_s;
  logic [DATA_WIDTH-1:0] rd_op_s;
  logic [DATA_WIDTH-1:0] rd_arg_s;

  // Handshake decodes; a jump overrides fetch, push and pop alike.
  always_comb begin
    issue_s  = (state_r == ST_FETCH) && (count_r < 2'd2) && !JUMP_EN;
    push_s   = (state_r == ST_WAIT) && MEM_RVALID && !JUMP_EN;
    pop_s    = valid_r && INSTR_READY && !JUMP_EN;
    rd_op_s  = MEM_RDATA[INSTRUCTION_WIDTH-1 -: DATA_WIDTH];
    rd_arg_s = MEM_RDATA[DATA_WIDTH-1:0];
  end

  // Fetch sequencer: request issue, fetch pc and in-flight read tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_FETCH;
      fetch_pc_r <= PC_ZERO;
      mem_req_r  <= 1'b0;
      mem_addr_r <= PC_ZERO;
    end else begin
      mem_req_r <= issue_s;
      if (issue_s) begin
        mem_addr_r <= fetch_pc_r;
        fetch_pc_r <= fetch_pc_r + PC_ONE;
      end else if (JUMP_EN) begin
        fetch_pc_r <= JUMP_ADDR;
      end
      case (state_r)
        ST_FETCH:   state_r <= issue_s ? ST_WAIT : ST_FETCH;
        // A jump with the read still in flight must swallow its late data.
        ST_WAIT: begin
          if (MEM_RVALID)   state_r <= ST_FETCH;
          else if (JUMP_EN) state_r <= ST_DISCARD;
          else              state_r <= ST_WAIT;
        end
        ST_DISCARD: state_r <= MEM_RVALID ? ST_FETCH : ST_DISCARD;
        default:    state_r <= ST_FETCH;
      endcase
    end
  end

  // Two-entry buffer; the head registers drive the instruction outputs directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r    <= 2'd0;
      valid_r    <= 1'b0;
      head_op_r  <= D_ZERO;
      head_arg_r <= D_ZERO;
      head_pc_r  <= PC_ZERO;
      tail_op_r  <= D_ZERO;
      tail_arg_r <= D_ZERO;
      tail_pc_r  <= PC_ZERO;
    end else if (JUMP_EN) begin
      count_r <= 2'd0;
      valid_r <= 1'b0;
    end else begin
      case (count_r)
        2'd0: begin
          if (push_s) begin
            head_op_r  <= rd_op_s;
            head_arg_r <= rd_arg_s;
            head_pc_r  <= mem_addr_r;
            count_r    <= 2'd1;
            valid_r    <= 1'b1;
          end
        end
        2'd1: begin
          if (push_s && pop_s) begin
            head_op_r  <= rd_op_s;
            head_arg_r <= rd_arg_s;
            head_pc_r  <= mem_addr_r;
          end else if (push_s) begin
            tail_op_r  <= rd_op_s;
            tail_arg_r <= rd_arg_s;
            tail_pc_r  <= mem_addr_r;
            count_r    <= 2'd2;
          end else if (pop_s) begin
            count_r <= 2'd0;
            valid_r <= 1'b0;
          end
        end
        2'd2: begin
          if (pop_s) begin
            head_op_r  <= tail_op_r;
            head_arg_r <= tail_arg_r;
            head_pc_r  <= tail_pc_r;
            if (push_s) begin
              tail_op_r  <= rd_op_s;
              tail_arg_r <= rd_arg_s;
              tail_pc_r  <= mem_addr_r;
            end else begin
              count_r <= 2'd1;
            end
          end
        end
        default: begin
          count_r <= 2'd0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign MEM_REQ     = mem_req_r;
  assign MEM_ADDR    = mem_addr_r;
  assign INSTR_VALID = valid_r;
  assign INSTR_OUT   = head_op_r;
  assign ARG_OUT     = head_arg_r;
  assign INSTR_PC    = head_pc_r;
  assign BUF_COUNT   = count_r;

endmodule
